// File: rtl/pwm_mode_ctrl.sv
// pwm_mode_ctrl: mode and duty controller for the PWM generator.
// The controller steps through three modes: off (IDLE), manual duty (MANUAL)
// and an automatic triangular duty ramp (BREATH). It owns the free-running
// period counter, the shadowed compare register and the registered output pin.
//
// Ports:
//   sys_clk        in   system clock
//   sys_rst_n      in   asynchronous active-low reset
//   key_up_flag    in   1-cycle debounced "up" press
//   key_dn_flag    in   1-cycle debounced "down" press
//   key_mode_flag  in   1-cycle debounced "mode" press
//   pwm_out        out  registered PWM output
//   duty           out  requested duty in clock counts (0..PERIOD)
//   mode           out  0 IDLE, 1 MANUAL, 2 BREATH
//   period_end     out  1-cycle pulse on the last cycle of each period
//
// Build option: define PWM_SOFT_START_EN to ramp duty from 0 up to the
// setpoint on entry to MANUAL instead of jumping straight to it.
module pwm_mode_ctrl #(
  parameter logic [15:0] PERIOD    = 16'd50_000,
  parameter logic [15:0] DUTY_STEP = 16'd5_000,
  parameter logic [19:0] RAMP_DIV  = 20'd50_000,
  parameter logic [15:0] RAMP_INC  = 16'd50
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        key_up_flag,
  input  logic        key_dn_flag,
  input  logic        key_mode_flag,
  output logic        pwm_out,
  output logic [15:0] duty,
  output logic [1:0]  mode,
  output logic        period_end
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MANUAL = 2'd1;
  localparam logic [1:0] ST_BREATH = 2'd2;

  logic [1:0]  state;
  logic [15:0] cnt, cnt_next;
  logic [15:0] duty_act, duty_act_next;
  logic [15:0] setpoint, sp_next, sp_inc, sp_dec;
  logic [16:0] sp_up, duty_up;
  logic [19:0] ramp_cnt;
  logic        ramp_tick;
  logic        dir_down;
`ifdef PWM_SOFT_START_EN
  logic        soft;
`endif

  assign mode = state;

  // Period counter and duty shadow. The output compare is evaluated on the
  // next-cycle counter and compare values so pwm_out lines up with cnt.
  always_comb begin
    cnt_next      = (cnt == PERIOD - 16'd1) ? '0 : cnt + 16'd1;
    duty_act_next = (cnt == PERIOD - 16'd1) ? duty : duty_act;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt        <= '0;
      duty_act   <= '0;
      period_end <= 1'b0;
      pwm_out    <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      duty_act   <= duty_act_next;
      period_end <= (cnt_next == PERIOD - 16'd1);
      pwm_out    <= (cnt_next < duty_act_next);
    end
  end

  // Saturating 17-bit arithmetic for setpoint steps and ramp increments.
  always_comb begin
    sp_up   = {1'b0, setpoint} + {1'b0, DUTY_STEP};
    sp_inc  = (sp_up >= {1'b0, PERIOD}) ? PERIOD : sp_up[15:0];
    sp_dec  = (setpoint <= DUTY_STEP) ? '0 : setpoint - DUTY_STEP;
    sp_next = setpoint;
    if (key_up_flag && !key_dn_flag)
      sp_next = sp_inc;
    else if (key_dn_flag && !key_up_flag)
      sp_next = sp_dec;
    duty_up   = {1'b0, duty} + {1'b0, RAMP_INC};
    ramp_tick = (ramp_cnt == RAMP_DIV - 20'd1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      duty     <= '0;
      setpoint <= PERIOD >> 1;
      ramp_cnt <= '0;
      dir_down <= 1'b0;
`ifdef PWM_SOFT_START_EN
      soft     <= 1'b0;
`endif
    end else if (key_mode_flag) begin
      // Mode press wins; coincident up/dn presses are dropped.
      ramp_cnt <= '0;
      case (state)
        ST_IDLE: begin
          state <= ST_MANUAL;
`ifdef PWM_SOFT_START_EN
          duty  <= '0;
          soft  <= 1'b1;
`else
          duty  <= setpoint;
`endif
        end
        ST_MANUAL: begin
          state    <= ST_BREATH;
          duty     <= '0;
          dir_down <= 1'b0;
`ifdef PWM_SOFT_START_EN
          soft     <= 1'b0;
`endif
        end
        default: begin
          state <= ST_IDLE;
          duty  <= '0;
        end
      endcase
    end else begin
      case (state)
        ST_IDLE: begin
          duty     <= '0;
          ramp_cnt <= '0;
        end
        ST_MANUAL: begin
          setpoint <= sp_next;
`ifdef PWM_SOFT_START_EN
          if (soft) begin
            ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 20'd1;
            // The (possibly just adjusted) setpoint is the live target.
            if (duty >= sp_next) begin
              duty <= sp_next;
              soft <= 1'b0;
            end else if (ramp_tick) begin
              if (duty_up >= {1'b0, sp_next}) begin
                duty <= sp_next;
                soft <= 1'b0;
              end else begin
                duty <= duty_up[15:0];
              end
            end
          end else begin
            duty     <= sp_next;
            ramp_cnt <= '0;
          end
`else
          duty     <= sp_next;
          ramp_cnt <= '0;
`endif
        end
        ST_BREATH: begin
          ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 20'd1;
          if (ramp_tick) begin
            if (!dir_down) begin
              if (duty_up >= {1'b0, PERIOD}) begin
                duty     <= PERIOD;
                dir_down <= 1'b1;
              end else begin
                duty <= duty_up[15:0];
              end
            end else begin
              if (duty <= RAMP_INC) begin
                duty     <= '0;
                dir_down <= 1'b0;
              end else begin
                duty <= duty - RAMP_INC;
              end
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          duty     <= '0;
          ramp_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_mode_ctrl.sv
// Directed testbench for pwm_mode_ctrl with PERIOD=100, DUTY_STEP=10,
// RAMP_DIV=4, RAMP_INC=25. Inputs change and outputs are sampled on the
// falling clock edge; the period counter is modelled by a cycle count.
module tb_pwm_mode_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        key_up_flag = 1'b0;
  logic        key_dn_flag = 1'b0;
  logic        key_mode_flag = 1'b0;
  logic        pwm_out;
  logic [15:0] duty;
  logic [1:0]  mode;
  logic        period_end;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  pwm_mode_ctrl #(
    .PERIOD   (16'd100),
    .DUTY_STEP(16'd10),
    .RAMP_DIV (20'd4),
    .RAMP_INC (16'd25)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .key_up_flag  (key_up_flag),
    .key_dn_flag  (key_dn_flag),
    .key_mode_flag(key_mode_flag),
    .pwm_out      (pwm_out),
    .duty         (duty),
    .mode         (mode),
    .period_end   (period_end)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference period counter: value seen on a falling edge is cyc % 100.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  // One-cycle key pulse; starts and ends on a falling edge.
  task automatic pulse(input bit up, input bit dn, input bit md);
    key_up_flag   = up;
    key_dn_flag   = dn;
    key_mode_flag = md;
    @(negedge sys_clk);
    key_up_flag   = 1'b0;
    key_dn_flag   = 1'b0;
    key_mode_flag = 1'b0;
  endtask

  // Observes the first whole period that starts at least one cycle from now.
  task automatic measure(output int highs, output int lead, output int pends,
                         output int pe_last);
    int guard;
    highs = 0; lead = 0; pends = 0; pe_last = 0; guard = 0;
    @(negedge sys_clk);
    while ((cyc % 100) != 0 && guard < 200) begin
      @(negedge sys_clk);
      guard++;
    end
    for (int i = 0; i < 100; i++) begin
      if (pwm_out === 1'b1) begin
        highs++;
        if (lead == i) lead++;
      end
      if (period_end === 1'b1) pends++;
      if (i == 99) pe_last = (period_end === 1'b1) ? 1 : 0;
      @(negedge sys_clk);
    end
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL rst_mode: got %0d expected 0", mode); end
    n_cmp++; if (duty !== 16'd0) begin n_bad++; $display("FAIL rst_duty: got %0d expected 0", duty); end
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL rst_pwm: got %b expected 0", pwm_out); end
    n_cmp++; if (period_end !== 1'b0) begin n_bad++; $display("FAIL rst_pend: got %b expected 0", period_end); end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_manual_entry;
    int h, l, p, pl;
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++; if (mode !== 2'd1) begin n_bad++; $display("FAIL t1_mode: got %0d expected 1", mode); end
    n_cmp++; if (duty !== 16'd50) begin n_bad++; $display("FAIL t1_duty: got %0d expected 50", duty); end
    for (int r = 0; r < 2; r++) begin
      measure(h, l, p, pl);
      n_cmp++; if (h != 50) begin n_bad++; $display("FAIL t1_highs: got %0d expected 50", h); end
      n_cmp++; if (l != 50) begin n_bad++; $display("FAIL t1_lead: got %0d expected 50", l); end
      n_cmp++; if (p != 1) begin n_bad++; $display("FAIL t1_pend_count: got %0d expected 1", p); end
      n_cmp++; if (pl != 1) begin n_bad++; $display("FAIL t1_pend_last: got %0d expected 1", pl); end
    end
  endtask

  task automatic test_saturation;
    int up_exp[6] = '{60, 70, 80, 90, 100, 100};
    int e, h, l, p, pl;
    for (int i = 0; i < 6; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      n_cmp++; if (duty !== 16'(up_exp[i])) begin n_bad++; $display("FAIL t2_up%0d: got %0d expected %0d", i, duty, up_exp[i]); end
    end
    measure(h, l, p, pl);
    n_cmp++; if (h != 100) begin n_bad++; $display("FAIL t2_full_high: got %0d expected 100", h); end
    for (int i = 0; i < 11; i++) begin
      pulse(1'b0, 1'b1, 1'b0);
      e = (90 - 10 * i < 0) ? 0 : 90 - 10 * i;
      n_cmp++; if (duty !== 16'(e)) begin n_bad++; $display("FAIL t2_dn%0d: got %0d expected %0d", i, duty, e); end
    end
    measure(h, l, p, pl);
    n_cmp++; if (h != 0) begin n_bad++; $display("FAIL t2_zero_high: got %0d expected 0", h); end
    n_cmp++; if (p != 1) begin n_bad++; $display("FAIL t2_pend_count: got %0d expected 1", p); end
  endtask

  task automatic test_mid_period;
    int h, l, p, pl, guard;
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0);
    n_cmp++; if (duty !== 16'd50) begin n_bad++; $display("FAIL t3_pre: got %0d expected 50", duty); end
    measure(h, l, p, pl);
    guard = 0;
    while ((cyc % 100) != 30 && guard < 200) begin @(negedge sys_clk); guard++; end
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++; if (duty !== 16'd60) begin n_bad++; $display("FAIL t3_duty: got %0d expected 60", duty); end
    // Remainder of the current period (counter 31..99) keeps the old compare.
    h = 0; guard = 0;
    while ((cyc % 100) != 0 && guard < 200) begin
      if (pwm_out === 1'b1) h++;
      @(negedge sys_clk);
      guard++;
    end
    n_cmp++; if (h != 19) begin n_bad++; $display("FAIL t3_old_tail: got %0d expected 19", h); end
    measure(h, l, p, pl);
    n_cmp++; if (h != 60) begin n_bad++; $display("FAIL t3_new_highs: got %0d expected 60", h); end
    n_cmp++; if (l != 60) begin n_bad++; $display("FAIL t3_new_lead: got %0d expected 60", l); end
  endtask

  task automatic test_mode_priority;
    pulse(1'b0, 1'b1, 1'b0);
    n_cmp++; if (duty !== 16'd50) begin n_bad++; $display("FAIL t4_pre: got %0d expected 50", duty); end
    pulse(1'b1, 1'b0, 1'b1);
    n_cmp++; if (mode !== 2'd2) begin n_bad++; $display("FAIL t4_mode: got %0d expected 2", mode); end
    n_cmp++; if (duty !== 16'd0) begin n_bad++; $display("FAIL t4_duty: got %0d expected 0", duty); end
  endtask

  // Must follow test_mode_priority with no idle cycle in between.
  task automatic test_breath;
    int seq[10] = '{0, 25, 50, 75, 100, 75, 50, 25, 0, 25};
    for (int k = 1; k < 40; k++) begin
      @(negedge sys_clk);
      n_cmp++; if (duty !== 16'(seq[k / 4])) begin n_bad++; $display("FAIL t5_k%0d: got %0d expected %0d", k, duty, seq[k / 4]); end
    end
  endtask

  task automatic test_setpoint_retained;
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL t4_idle_mode: got %0d expected 0", mode); end
    n_cmp++; if (duty !== 16'd0) begin n_bad++; $display("FAIL t4_idle_duty: got %0d expected 0", duty); end
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++; if (mode !== 2'd1) begin n_bad++; $display("FAIL t4_back_mode: got %0d expected 1", mode); end
    n_cmp++; if (duty !== 16'd50) begin n_bad++; $display("FAIL t4_back_duty: got %0d expected 50", duty); end
  endtask

  task automatic test_async_reset;
    pulse(1'b0, 1'b0, 1'b1);
    repeat (13) @(negedge sys_clk);
    n_cmp++; if (duty !== 16'd75) begin n_bad++; $display("FAIL t6_pre: got %0d expected 75", duty); end
    #2 sys_rst_n = 1'b0;
    #1;
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL t6_pwm: got %b expected 0", pwm_out); end
    n_cmp++; if (duty !== 16'd0) begin n_bad++; $display("FAIL t6_duty: got %0d expected 0", duty); end
    n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL t6_mode: got %0d expected 0", mode); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++; if (mode !== 2'd1) begin n_bad++; $display("FAIL t6_post_mode: got %0d expected 1", mode); end
    n_cmp++; if (duty !== 16'd50) begin n_bad++; $display("FAIL t6_post_duty: got %0d expected 50", duty); end
  endtask

  initial begin
    @(negedge sys_clk);
    test_reset;
    test_manual_entry;
    test_saturation;
    test_mid_period;
    test_mode_priority;
    test_breath;
    test_setpoint_retained;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case a task loop misbehaves.
  initial begin
    #500000;
    $display("FAIL timeout: got no completion, expected completion before 500000");
    $fatal(1);
  end

endmodule
